// File: rtl/ldmem_tag_ctrl_pkg.sv
// Shared types for the ldmem tag controller: FSM state encoding, perf counter width
// and the MAX_OUTST legality helper.
package ldmem_tag_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ldmem_state_e;

  localparam int PERF_W = 32;

  // The outstanding limit must be a power of two so the counter width is exact.
  function automatic bit outst_legal(input int n);
    return (n >= 1) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/ldmem_outst_cnt.sv
// Outstanding-burst counter: +1 per request handshake, -1 per returned last beat.
// A simultaneous inc/dec leaves the count unchanged; a lone dec at zero is dropped and flagged.
module ldmem_outst_cnt #(
  parameter int MAX_OUTST = 8,
  parameter int OW        = $clog2(MAX_OUTST) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [OW-1:0] count,
  output logic          full,
  output logic          underflow
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign full      = (count == OW'(MAX_OUTST));
  assign underflow = dec && !inc && (count == '0);

endmodule

// File: rtl/ldmem_tag_ctrl.sv
// Load-memory sequencer for one double-buffered buffer: issues strided DDR read bursts
// for the current ldmem tag and reports completion. Optional perf counters: LDMEM_PERF_CNT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for ldmem_tag_ready; latches cfg_* and tag on start
// ST_ISSUE | issuing bursts, throttled by the outstanding limit
// ST_DRAIN | all bursts issued, waiting for outstanding to reach zero
// ST_DONE  | one-cycle ldmem_tag_done pulse, back to idle
module ldmem_tag_ctrl
  import ldmem_tag_ctrl_pkg::*;
#(
  parameter int NUM_TAGS  = 2,
  parameter int TAG_W     = $clog2(NUM_TAGS),
  parameter int ADDR_W    = 42,
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_OUTST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_num_bursts,
  input  logic [LEN_W-1:0]  cfg_burst_len,
  input  logic              ldmem_tag_ready,
  input  logic [TAG_W-1:0]  ldmem_tag,
  output logic              ldmem_tag_done,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [LEN_W-1:0]  rd_req_len,
  output logic [TAG_W-1:0]  rd_req_tag,
  input  logic              rd_resp_valid,
  input  logic              rd_resp_last,
  output logic              err_resp_unexp,
  output logic [PERF_W-1:0] perf_active_cyc,
  output logic [PERF_W-1:0] perf_stall_cyc
);

  localparam int OW = $clog2(MAX_OUTST) + 1;

  if (!outst_legal(MAX_OUTST)) begin : g_bad_outst
    $error("ldmem_tag_ctrl: MAX_OUTST must be a power of 2 and >= 1");
  end

  ldmem_state_e      state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  len_q;
  logic [TAG_W-1:0]  tag_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              done_q;
  logic              err_q;

  logic [OW-1:0]     outst;
  logic              outst_full;
  logic              outst_underflow;
  logic              req_hs;
  logic              resp_last;

  assign rd_req_valid = (state == ST_ISSUE) && !outst_full;
  assign req_hs       = rd_req_valid && rd_req_ready;
  assign resp_last    = rd_resp_valid && rd_resp_last;

  ldmem_outst_cnt #(
    .MAX_OUTST (MAX_OUTST),
    .OW        (OW)
  ) u_outst_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc       (req_hs),
    .dec       (resp_last),
    .count     (outst),
    .full      (outst_full),
    .underflow (outst_underflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      tag_q       <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ldmem_tag_ready) begin
            addr_q      <= cfg_base_addr;
            stride_q    <= cfg_stride;
            len_q       <= cfg_burst_len;
            tag_q       <= ldmem_tag;
            remaining_q <= cfg_num_bursts;
            if (cfg_num_bursts == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (req_hs) begin
            // Address arithmetic wraps modulo 2^ADDR_W on purpose.
            addr_q      <= addr_q + stride_q;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == CNT_W'(1)) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (outst == '0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (outst_underflow) begin
      err_q <= 1'b1;
    end
  end

  assign ldmem_tag_done = done_q;
  assign rd_req_addr    = addr_q;
  assign rd_req_len     = len_q;
  assign rd_req_tag     = tag_q;
  assign err_resp_unexp = err_q;

`ifdef LDMEM_PERF_CNT_EN
  logic [PERF_W-1:0] active_q;
  logic [PERF_W-1:0] stall_q;

  // Both counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      stall_q  <= '0;
    end else begin
      if ((state != ST_IDLE) && (active_q != '1)) begin
        active_q <= active_q + 1'b1;
      end
      if (rd_req_valid && !rd_req_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign perf_active_cyc = active_q;
  assign perf_stall_cyc  = stall_q;
`else
  assign perf_active_cyc = '0;
  assign perf_stall_cyc  = '0;
`endif

endmodule

// File: tb/tb_ldmem_tag_ctrl.sv
// Bench for ldmem_tag_ctrl: directed scenarios plus randomized transfers, all checked
// every cycle against a transaction-level reference model.
module tb_ldmem_tag_ctrl;

  localparam int ADDR_W    = 42;
  localparam int LEN_W     = 8;
  localparam int CNT_W     = 16;
  localparam int TAG_W     = 1;
  localparam int MAX_OUTST = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [ADDR_W-1:0] cfg_stride = '0;
  logic [CNT_W-1:0]  cfg_num_bursts = '0;
  logic [LEN_W-1:0]  cfg_burst_len = '0;
  logic              ldmem_tag_ready = 1'b0;
  logic [TAG_W-1:0]  ldmem_tag = '0;
  logic              ldmem_tag_done;
  logic              rd_req_valid;
  logic              rd_req_ready = 1'b0;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [LEN_W-1:0]  rd_req_len;
  logic [TAG_W-1:0]  rd_req_tag;
  logic              rd_resp_valid = 1'b0;
  logic              rd_resp_last = 1'b0;
  logic              err_resp_unexp;
  logic [31:0]       perf_active_cyc;
  logic [31:0]       perf_stall_cyc;

  always #5 clk = ~clk;

  ldmem_tag_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_stride      (cfg_stride),
    .cfg_num_bursts  (cfg_num_bursts),
    .cfg_burst_len   (cfg_burst_len),
    .ldmem_tag_ready (ldmem_tag_ready),
    .ldmem_tag       (ldmem_tag),
    .ldmem_tag_done  (ldmem_tag_done),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_req_addr     (rd_req_addr),
    .rd_req_len      (rd_req_len),
    .rd_req_tag      (rd_req_tag),
    .rd_resp_valid   (rd_resp_valid),
    .rd_resp_last    (rd_resp_last),
    .err_resp_unexp  (err_resp_unexp),
    .perf_active_cyc (perf_active_cyc),
    .perf_stall_cyc  (perf_stall_cyc)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one transfer = list of bursts base + i*stride, done two cycles
  // after the point where everything is issued and nothing is outstanding.
  bit                m_busy = 1'b0;
  int                m_cd = -1;
  int                m_left = 0;
  int                m_issued = 0;
  int                m_outst = 0;
  bit                m_err = 1'b0;
  logic [ADDR_W-1:0] m_base = '0;
  logic [ADDR_W-1:0] m_stride = '0;
  logic [LEN_W-1:0]  m_len = '0;
  logic [TAG_W-1:0]  m_tag = '0;
  longint            m_act = 0;
  longint            m_stall = 0;

  int dut_hs = 0;
  int dut_done = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input bit rdy, input bit rv, input bit rl);
    bit                exp_valid;
    bit                exp_done;
    bit                hs;
    bit                dec;
    bit                tag_adv;
    logic [ADDR_W-1:0] exp_addr;
    rd_req_ready  = rdy;
    rd_resp_valid = rv;
    rd_resp_last  = rl;
    exp_valid = m_busy && (m_left > 0) && (m_outst < MAX_OUTST);
    exp_done  = m_busy && (m_cd == 0);
    exp_addr  = m_base + ADDR_W'(m_issued) * m_stride;
    check_val("req_valid", 64'(rd_req_valid), 64'(exp_valid));
    check_val("tag_done", 64'(ldmem_tag_done), 64'(exp_done));
    check_val("err_resp_unexp", 64'(err_resp_unexp), 64'(m_err));
    if (exp_valid && rd_req_valid) begin
      check_val("req_addr", 64'(rd_req_addr), 64'(exp_addr));
      check_val("req_len", 64'(rd_req_len), 64'(m_len));
      check_val("req_tag", 64'(rd_req_tag), 64'(m_tag));
    end
`ifdef LDMEM_PERF_CNT_EN
    check_val("perf_active", 64'(perf_active_cyc), 64'(m_act));
    check_val("perf_stall", 64'(perf_stall_cyc), 64'(m_stall));
`else
    check_val("perf_active", 64'(perf_active_cyc), 64'd0);
    check_val("perf_stall", 64'(perf_stall_cyc), 64'd0);
`endif
    if (rd_req_valid && rd_req_ready) dut_hs++;
    if (ldmem_tag_done) dut_done++;

    hs      = exp_valid && rdy;
    dec     = rv && rl;
    tag_adv = 1'b0;
    if (m_busy) m_act++;
    if (exp_valid && !rdy) m_stall++;
    if (dec && (m_outst == 0) && !hs) m_err = 1'b1;
    if (hs) begin
      m_outst++;
      m_issued++;
      m_left--;
    end
    if (dec && (m_outst > 0)) m_outst--;

    if (m_busy && (m_cd == 0)) begin
      m_busy  = 1'b0;
      m_cd    = -1;
      tag_adv = 1'b1;
    end else if (m_cd > 0) begin
      m_cd--;
    end else if (!m_busy) begin
      if (ldmem_tag_ready) begin
        m_busy   = 1'b1;
        m_base   = cfg_base_addr;
        m_stride = cfg_stride;
        m_len    = cfg_burst_len;
        m_tag    = ldmem_tag;
        m_left   = int'(cfg_num_bursts);
        m_issued = 0;
        m_cd     = (cfg_num_bursts == '0) ? 0 : -1;
      end
    end else if ((m_left == 0) && (m_outst == 0)) begin
      m_cd = 1;
    end

    @(posedge clk);
    @(negedge clk);
    if (tag_adv) ldmem_tag = ~ldmem_tag;
  endtask

  task automatic do_reset();
    rd_req_ready    = 1'b0;
    rd_resp_valid   = 1'b0;
    rd_resp_last    = 1'b0;
    ldmem_tag_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    ldmem_tag = '0;
    m_busy  = 1'b0;
    m_cd    = -1;
    m_left  = 0;
    m_outst = 0;
    m_err   = 1'b0;
    m_act   = 0;
    m_stall = 0;
    check_val("rst_valid", 64'(rd_req_valid), 64'd0);
    check_val("rst_done", 64'(ldmem_tag_done), 64'd0);
    check_val("rst_err", 64'(err_resp_unexp), 64'd0);
    check_val("rst_addr", 64'(rd_req_addr), 64'd0);
    check_val("rst_len", 64'(rd_req_len), 64'd0);
    check_val("rst_tag", 64'(rd_req_tag), 64'd0);
    check_val("rst_perf_active", 64'(perf_active_cyc), 64'd0);
    check_val("rst_perf_stall", 64'(perf_stall_cyc), 64'd0);
  endtask

  // Random ready/response traffic until the model returns to idle.
  task automatic run_random(input int budget, input int rdy_pct, input int resp_pct);
    int n;
    bit rdy;
    bit rv;
    bit rl;
    n = 0;
    while (m_busy && (n < budget)) begin
      rdy = ($urandom_range(99) < rdy_pct);
      rv  = ($urandom_range(99) < resp_pct) && (m_outst > 0);
      rl  = rv && ($urandom_range(2) == 0);
      cyc(rdy, rv, rl);
      n++;
    end
    check_val("xfer_timeout", 64'(m_busy), 64'd0);
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                            input int num, input int len);
    cfg_base_addr   = base;
    cfg_stride      = stride;
    cfg_num_bursts  = CNT_W'(num);
    cfg_burst_len   = LEN_W'(len);
    ldmem_tag_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    ldmem_tag_ready = 1'b0;
  endtask

  int hs0;
  int d0;

  initial begin
    do_reset();
    cyc(0, 0, 0);

    // T1: single burst, one 4-beat response
    hs0 = dut_hs;
    d0  = dut_done;
    start_xfer(42'h1000, 42'h40, 1, 3);
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    check_val("t1_done_lat", 64'(ldmem_tag_done), 64'd1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check_val("t1_req_count", 64'(dut_hs - hs0), 64'd1);
    check_val("t1_done_count", 64'(dut_done - d0), 64'd1);

    // T2: address wrap, tag follows tag_sync across back-to-back tags
    do_reset();
    cfg_base_addr   = {ADDR_W{1'b1}} - 42'h3f;
    cfg_stride      = 42'h40;
    cfg_num_bursts  = 16'd3;
    cfg_burst_len   = 8'd7;
    ldmem_tag_ready = 1'b1;
    cyc(0, 0, 0);
    run_random(400, 70, 60);
    cyc(1, 0, 0);
    ldmem_tag_ready = 1'b0;
    check_val("t2_second_tag", 64'(m_tag), 64'd1);
    run_random(400, 70, 60);

    // T3: outstanding limit and backpressure
    hs0 = dut_hs;
    start_xfer(ADDR_W'({$urandom(), $urandom()}), 42'h100, 12, 15);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0);
    check_val("t3_reqs_at_limit", 64'(dut_hs - hs0), 64'd8);
    check_val("t3_valid_full", 64'(rd_req_valid), 64'd0);
    cyc(0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    check_val("t3_reqs_after_one", 64'(dut_hs - hs0), 64'd9);
    run_random(1000, 80, 50);

    // T4: simultaneous handshake/last, then an unexpected last in idle
    do_reset();
    start_xfer(42'h2000, 42'h80, 2, 1);
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    check_val("t4_err_sticky", 64'(err_resp_unexp), 64'd1);
    start_xfer(42'h3000, 42'h10, 1, 0);
    run_random(200, 100, 100);

    // T5: zero bursts
    hs0 = dut_hs;
    d0  = dut_done;
    start_xfer(42'h4000, 42'h40, 0, 3);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    check_val("t5_no_reqs", 64'(dut_hs - hs0), 64'd0);
    check_val("t5_one_done", 64'(dut_done - d0), 64'd1);

    // T6: reset in the middle of a transfer, then a fresh start
    do_reset();
    start_xfer(42'h5000, 42'h200, 4, 2);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    do_reset();
    d0 = dut_done;
    for (int i = 0; i < 6; i++) cyc(1, 1, 0);
    check_val("t6_no_done", 64'(dut_done - d0), 64'd0);
    start_xfer(42'h7_0000, 42'h20, 3, 4);
    check_val("t6_new_base", 64'(rd_req_addr), 64'h7_0000);
    run_random(400, 60, 60);

    // Randomized transfers; cfg and tag_ready are scrambled after sampling
    for (int t = 0; t < 25; t++) begin
      cfg_base_addr   = ADDR_W'({$urandom(), $urandom()});
      cfg_stride      = ($urandom_range(3) == 0) ? ADDR_W'({$urandom(), $urandom()})
                                                : ADDR_W'($urandom_range(4096));
      cfg_num_bursts  = CNT_W'($urandom_range(20));
      cfg_burst_len   = LEN_W'($urandom());
      ldmem_tag_ready = 1'b1;
      cyc(1'($urandom()), 1'b0, 1'b0);
      ldmem_tag_ready = 1'($urandom());
      cfg_base_addr   = ADDR_W'({$urandom(), $urandom()});
      cfg_num_bursts  = CNT_W'($urandom());
      run_random(2000, 30 + $urandom_range(70), 20 + $urandom_range(60));
      ldmem_tag_ready = 1'b0;
      cyc(0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
